// File: rtl/core_pkg.sv
// ----------------------------------------------------------------------------
// core_pkg: opcodes, reset vector and fetch state encoding shared by the core.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package core_pkg;

  localparam logic [6:0]  OP_JAL           = 7'b1101111;
  localparam logic [6:0]  OP_BRANCH        = 7'b1100011;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h3000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_npc_pred.sv
// ----------------------------------------------------------------------------
// fetch_npc_pred: static next-PC guess (JAL and backward branches taken).
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_npc_pred
  import core_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [31:0] i_inst,
  output logic [31:0] o_npc
);

  logic [31:0] w_imm_j;
  logic [31:0] w_imm_b;
  logic        w_is_jal;
  logic        w_is_bwd_branch;

  assign w_imm_j = {{12{i_inst[31]}}, i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
  assign w_imm_b = {{20{i_inst[31]}}, i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};

  assign w_is_jal        = (i_inst[6:2] == OP_JAL[6:2]);
  // Sign bit of the B immediate is inst[31]: set means a backward target.
  assign w_is_bwd_branch = (i_inst[6:0] == OP_BRANCH) && i_inst[31];

  always_comb begin
    o_npc = i_pc + 32'd4;
    if (w_is_jal) begin
      o_npc = i_pc + w_imm_j;
    end else if (w_is_bwd_branch) begin
      o_npc = i_pc + w_imm_b;
    end
  end

endmodule

`default_nettype wire

// File: rtl/inst_fetch_unit.sv
// ----------------------------------------------------------------------------
// inst_fetch_unit: single-outstanding instruction fetch with one-entry buffer.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module inst_fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] flush_dnpc,
  input  logic        jump_flush,
  input  logic [31:0] jump_dnpc,
  output logic        mem_arvalid,
  input  logic        mem_arready,
  output logic [31:0] mem_araddr,
  input  logic        mem_rvalid,
  output logic        mem_rready,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_araddr;
  logic         r_drop;
  logic [31:0]  r_buf_pc;
  logic [31:0]  r_buf_inst;

  logic [31:0]  w_pc_nxt;
  logic [31:0]  w_araddr_nxt;
  logic         w_drop_nxt;
  logic [31:0]  w_buf_pc_nxt;
  logic [31:0]  w_buf_inst_nxt;
  logic [31:0]  w_pred_npc;
  logic         w_redir;
  logic [31:0]  w_target;

  assign w_redir  = flush | jump_flush;
  assign w_target = flush ? flush_dnpc : jump_dnpc;

  fetch_npc_pred u_pred (
    .i_pc   (r_fetch_pc),
    .i_inst (mem_rdata),
    .o_npc  (w_pred_npc)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_fetch_pc;
    w_drop_nxt     = r_drop;
    w_buf_pc_nxt   = r_buf_pc;
    w_buf_inst_nxt = r_buf_inst;
    mem_arvalid    = 1'b0;
    mem_rready     = 1'b0;
    out_valid      = 1'b0;

    case (r_state)
      S_REQ: begin
        mem_arvalid = 1'b1;
        if (mem_arready) w_state_nxt = S_WAIT;
        if (w_redir)     w_drop_nxt  = 1'b1;
      end
      S_WAIT: begin
        mem_rready = 1'b1;
        if (mem_rvalid) begin
          if (r_drop || w_redir) begin
            w_state_nxt = S_REQ;
            w_drop_nxt  = 1'b0;
          end else begin
            w_buf_pc_nxt   = r_fetch_pc;
            w_buf_inst_nxt = mem_rdata;
            w_pc_nxt       = w_pred_npc;
            w_state_nxt    = S_HOLD;
          end
        end else if (w_redir) begin
          w_drop_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        out_valid = ~w_redir;
        if (w_redir || out_ready) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_REQ;
    endcase

    if (w_redir) w_pc_nxt = w_target;

    // A pending, unaccepted request keeps its address even when fetch_pc is redirected.
    w_araddr_nxt = w_pc_nxt;
    if (r_state == S_REQ && !mem_arready) w_araddr_nxt = r_araddr;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_REQ;
      r_fetch_pc <= RESET_PC;
      r_araddr   <= RESET_PC;
      r_drop     <= 1'b0;
      r_buf_pc   <= 32'd0;
      r_buf_inst <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_pc_nxt;
      r_araddr   <= w_araddr_nxt;
      r_drop     <= w_drop_nxt;
      r_buf_pc   <= w_buf_pc_nxt;
      r_buf_inst <= w_buf_inst_nxt;
    end
  end

  assign mem_araddr = r_araddr;
  assign out_pc     = r_buf_pc;
  assign out_inst   = r_buf_inst;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_inst_fetch_unit: directed per-cycle vectors for the fetch stage.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_inst_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] flush_dnpc = 32'd0;
  logic        jump_flush = 1'b0;
  logic [31:0] jump_dnpc = 32'd0;
  logic        mem_arvalid;
  logic        mem_arready = 1'b0;
  logic [31:0] mem_araddr;
  logic        mem_rvalid = 1'b0;
  logic        mem_rready;
  logic [31:0] mem_rdata = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  inst_fetch_unit #(.RESET_PC(32'h3000_0000)) dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .flush_dnpc  (flush_dnpc),
    .jump_flush  (jump_flush),
    .jump_dnpc   (jump_dnpc),
    .mem_arvalid (mem_arvalid),
    .mem_arready (mem_arready),
    .mem_araddr  (mem_araddr),
    .mem_rvalid  (mem_rvalid),
    .mem_rready  (mem_rready),
    .mem_rdata   (mem_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_inst    (out_inst)
  );

  typedef struct {
    logic        ar;
    logic        rv;
    logic [31:0] rd;
    logic        ordy;
    logic        fl;
    logic [31:0] fd;
    logic        jf;
    logic [31:0] jd;
    logic        e_arv;
    logic [31:0] e_addr;
    logic        e_rr;
    logic        e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t vecs[$];
  vec_t post[$];

  task automatic add(input logic ar, input logic rv, input logic [31:0] rd, input logic ordy,
                     input logic fl, input logic [31:0] fd, input logic jf, input logic [31:0] jd,
                     input logic e_arv, input logic [31:0] e_addr, input logic e_rr,
                     input logic e_ov, input logic [31:0] e_pc, input logic [31:0] e_inst);
    vec_t v;
    v.ar = ar; v.rv = rv; v.rd = rd; v.ordy = ordy;
    v.fl = fl; v.fd = fd; v.jf = jf; v.jd = jd;
    v.e_arv = e_arv; v.e_addr = e_addr; v.e_rr = e_rr;
    v.e_ov = e_ov; v.e_pc = e_pc; v.e_inst = e_inst;
    vecs.push_back(v);
  endtask

  // Zero-wait fetch: request, response, then handoff to decode.
  task automatic fetch3(input logic [31:0] addr, input logic [31:0] word);
    add(1, 0, 0, 0, 0, 0, 0, 0, 1, addr, 0, 0, 0, 0);
    add(0, 1, word, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, addr, word);
  endtask

  task automatic check(input string name, input logic e_arv, input logic [31:0] e_addr,
                       input logic e_rr, input logic e_ov, input logic [31:0] e_pc,
                       input logic [31:0] e_inst);
    logic ok;
    ok = (mem_arvalid === e_arv) && (mem_rready === e_rr) && (out_valid === e_ov)
         && (!e_arv || mem_araddr === e_addr)
         && (!e_ov || (out_pc === e_pc && out_inst === e_inst));
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got arv=%b addr=%h rr=%b ov=%b pc=%h inst=%h, want arv=%b addr=%h rr=%b ov=%b pc=%h inst=%h",
               name, mem_arvalid, mem_araddr, mem_rready, out_valid, out_pc, out_inst,
               e_arv, e_addr, e_rr, e_ov, e_pc, e_inst);
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    @(negedge clock);
    mem_arready = v.ar;
    mem_rvalid  = v.rv;
    mem_rdata   = v.rd;
    out_ready   = v.ordy;
    flush       = v.fl;
    flush_dnpc  = v.fd;
    jump_flush  = v.jf;
    jump_dnpc   = v.jd;
    #1;
    check(name, v.e_arv, v.e_addr, v.e_rr, v.e_ov, v.e_pc, v.e_inst);
  endtask

  task automatic clear_inputs();
    mem_arready = 0; mem_rvalid = 0; mem_rdata = 0; out_ready = 0;
    flush = 0; flush_dnpc = 0; jump_flush = 0; jump_dnpc = 0;
  endtask

  initial begin
    // Basic fetch, stalls, JAL prediction, backward/forward branches.
    fetch3(32'h3000_0000, 32'h0000_0013);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h3000_0004, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h3000_0004, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 1, 32'h0080_006F, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h3000_0004, 32'h0080_006F);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h3000_0004, 32'h0080_006F);
    fetch3(32'h3000_000C, 32'h0000_0013);
    fetch3(32'h3000_0010, 32'hFE00_0EE3);
    fetch3(32'h3000_000C, 32'h0000_0463);
    // jump_flush while waiting for data: returned word dropped.
    add(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h3000_0010, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 32'h3000_0100, 0, 0, 1, 0, 0, 0);
    add(0, 1, 32'h0000_006F, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h3000_0100, 0, 0, 0, 0);
    add(0, 1, 32'h0080_006F, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    // Redirect in HOLD with out_ready: no handoff.
    add(0, 0, 0, 1, 0, 0, 1, 32'h3000_0000, 0, 0, 0, 0, 0, 0);
    fetch3(32'h3000_0000, 32'h0080_006F);
    // flush + jump_flush in REQ without handshake: address held, flush wins.
    add(0, 0, 0, 0, 1, 32'h3000_0200, 1, 32'h3000_0100, 1, 32'h3000_0008, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h3000_0008, 0, 0, 0, 0);
    add(0, 1, 32'h0000_0013, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    fetch3(32'h3000_0200, 32'h0000_0013);
    // Redirect coinciding with arready, then flush coinciding with rvalid.
    add(1, 0, 0, 0, 0, 0, 1, 32'h3000_0300, 1, 32'h3000_0204, 0, 0, 0, 0);
    add(0, 1, 32'h0000_0013, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h3000_0300, 0, 0, 0, 0);
    add(0, 1, 32'h0000_0013, 0, 1, 32'h3000_0400, 0, 0, 0, 0, 1, 0, 0, 0);
    fetch3(32'h3000_0400, 32'h0000_006F);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h3000_0400, 0, 0, 0, 0);
    post = vecs;
    vecs.delete();
    fetch3(32'h3000_0000, 32'h0000_0013);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h3000_0004, 0, 0, 0, 0);

    // Reset state.
    repeat (2) @(negedge clock);
    #1;
    check("reset_state", 1, 32'h3000_0000, 0, 0, 0, 0);
    reset = 0;

    foreach (post[i]) run_vec(post[i], $sformatf("vec%0d", i));

    // Reset while waiting with drop pending.
    @(negedge clock);
    mem_arready = 1; jump_flush = 1; jump_dnpc = 32'h3000_0500;
    #1;
    check("pre_reset_req", 1, 32'h3000_0400, 0, 0, 0, 0);
    @(negedge clock);
    clear_inputs();
    reset = 1;
    @(negedge clock);
    reset = 0;
    #1;
    check("mid_reset_state", 1, 32'h3000_0000, 0, 0, 0, 0);
    foreach (vecs[i]) run_vec(vecs[i], $sformatf("post_reset%0d", i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
